// File: rtl/gate_sweep_pkg.sv
// Shared types and sizes for the gate sweeper: FSM states, vector count, counter widths.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = $clog2(NUM_VEC);

endpackage

// File: rtl/gate_sweeper_dwell_counter.sv
// Modulo-DWELL counter: counts while enabled, pulses wrap on the final count and restarts.
module dwell_counter
  import gate_sweep_pkg::*;
#(
  parameter int DWELL = 10,
  parameter int W     = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic wrap
);

  logic [W-1:0] count;

  assign wrap = en && (count == W'(DWELL - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/gate_sweeper.sv
// Sweeps a 2-input gate through vectors 00,01,10,11, captures its truth table and compares
// it to EXPECTED. Define GATE_SWEEPER_REPEAT_EN to allow back-to-back sweeps from FINISH.
module gate_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int                 DWELL    = 10,
  parameter logic [NUM_VEC-1:0] EXPECTED = 4'b1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               in1,
  output logic               in2,
  input  logic               out_dut,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] truth_table,
  output logic               pass
);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic               wrap;
  logic               sweep_start;
  logic               last_vec;

  dwell_counter #(.DWELL(DWELL), .W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .en    (state == DRIVE),
    .clear (state != DRIVE),
    .wrap  (wrap)
  );

  assign last_vec = (idx == IDX_W'(NUM_VEC - 1));
  assign busy     = (state == DRIVE);
  // idx keeps its last value after a sweep, so the stimulus is gated by the state.
  assign in1      = busy & idx[1];
  assign in2      = busy & idx[0];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    sweep_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = DRIVE;
          sweep_start = 1'b1;
        end
      end
      DRIVE: begin
        if (wrap && last_vec) state_next = FINISH;
      end
      FINISH: begin
`ifdef GATE_SWEEPER_REPEAT_EN
        if (start) begin
          state_next  = DRIVE;
          sweep_start = 1'b1;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      truth_table <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state <= state_next;
      // The final table bit lands on the FINISH entry edge, so done/pass register out of FINISH.
      done  <= (state == FINISH);
      if (state == FINISH) pass <= (truth_table == EXPECTED);
      if (sweep_start) begin
        idx         <= '0;
        truth_table <= '0;
      end else if (busy && wrap) begin
        truth_table[idx] <= out_dut;
        if (!last_vec) idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
